point_loader: RTL

- Ingests the day-8 puzzle input as an ASCII byte stream of lines "x,y,z\n" over a valid/ready handshake.
- Parses each line to unsigned decimal coordinates and writes them into internal x/y/z coordinate memories.
- Exposes a synchronous read port so the distance/circuit solver can read points instead of preloading memories from files.
- Acts as the writer/producer end of the coordinate memories the solver consumes.

---
 rtl/point_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/point_loader.sv
// rtl/point_loader.sv - Parses "x,y,z\n" ASCII lines into x/y/z coordinate memories with a synchronous read port.
// Producer end of the coordinate memories consumed by the distance/circuit solver.
module point_loader #(
  parameter int NUM_ELEMENT = 1000,
  parameter int COORD_WIDTH = 17,
  parameter int IDX_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  input  logic [IDX_WIDTH-1:0]   rd_idx,
  output logic [COORD_WIDTH-1:0] rd_x,
  output logic [COORD_WIDTH-1:0] rd_y,
  output logic [COORD_WIDTH-1:0] rd_z,
  output logic                   done,
  output logic                   error,
  output logic [IDX_WIDTH:0]     num_points
);

  localparam int ACC_WIDTH = COORD_WIDTH + 4;
  localparam logic [ACC_WIDTH-1:0] COORD_MAX = {4'b0, {COORD_WIDTH{1'b1}}};
  localparam logic [IDX_WIDTH:0]   CAPACITY  = (IDX_WIDTH + 1)'(NUM_ELEMENT);

  typedef enum logic [1:0] {S_IDLE, S_PARSE, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {F_X, F_Y, F_Z} field_t;

  state_t                 state;
  field_t                 field, field_n;
  logic [COORD_WIDTH-1:0] acc, acc_n;
  logic [COORD_WIDTH-1:0] x_val, x_n;
  logic [COORD_WIDTH-1:0] y_val, y_n;
  logic                   digit_seen, ds_n;

  logic [COORD_WIDTH-1:0] mem_x [NUM_ELEMENT];
  logic [COORD_WIDTH-1:0] mem_y [NUM_ELEMENT];
  logic [COORD_WIDTH-1:0] mem_z [NUM_ELEMENT];

  logic                 is_digit, is_comma, is_nl, is_skip;
  logic [ACC_WIDTH-1:0] acc_mul;
  logic                 byte_err, commit, full, take, wr_en;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_comma = (in_data == 8'h2c);
  assign is_nl    = (in_data == 8'h0a);
  assign is_skip  = (in_data == 8'h0d) || (in_data == 8'h20);
  // acc*10+digit never exceeds ACC_WIDTH bits because acc itself is bounded by COORD_MAX
  assign acc_mul  = {4'b0, acc} * ACC_WIDTH'(10) + ACC_WIDTH'(in_data[3:0]);
  assign take     = (state == S_PARSE) && in_valid;
  assign full     = (num_points == CAPACITY);

  always_comb begin
    byte_err = 1'b0;
    field_n  = field;
    acc_n    = acc;
    ds_n     = digit_seen;
    x_n      = x_val;
    y_n      = y_val;
    if (is_digit) begin
      acc_n = acc_mul[COORD_WIDTH-1:0];
      ds_n  = 1'b1;
      if (acc_mul > COORD_MAX) byte_err = 1'b1;
    end else if (is_comma) begin
      if (field != F_Z && digit_seen) begin
        if (field == F_X) x_n = acc;
        else              y_n = acc;
        field_n = (field == F_X) ? F_Y : F_Z;
        acc_n   = '0;
        ds_n    = 1'b0;
      end else begin
        byte_err = 1'b1;
      end
    end else if (is_nl) begin
      if (!((field == F_X && !digit_seen) || (field == F_Z && digit_seen))) byte_err = 1'b1;
    end else if (!is_skip) begin
      byte_err = 1'b1;
    end
    // in_last closes a pending Z field exactly like a newline would
    commit = !byte_err && (is_nl || in_last) && (field_n == F_Z) && ds_n;
  end

  assign wr_en = take && commit && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      field      <= F_X;
      acc        <= '0;
      digit_seen <= 1'b0;
      x_val      <= '0;
      y_val      <= '0;
      num_points <= '0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if (state != S_PARSE) begin
      if (start) begin
        state      <= S_PARSE;
        field      <= F_X;
        acc        <= '0;
        digit_seen <= 1'b0;
        num_points <= '0;
        in_ready   <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
      end
    end else if (take) begin
      if (byte_err || (commit && full)) begin
        state    <= S_ERR;
        in_ready <= 1'b0;
        error    <= 1'b1;
      end else begin
        x_val <= x_n;
        y_val <= y_n;
        if (commit) begin
          num_points <= num_points + 1'b1;
          field      <= F_X;
          acc        <= '0;
          digit_seen <= 1'b0;
        end else begin
          field      <= field_n;
          acc        <= acc_n;
          digit_seen <= ds_n;
        end
        if (in_last) begin
          in_ready <= 1'b0;
          if (commit || (field_n == F_X && !ds_n)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ERR;
            error <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[num_points[IDX_WIDTH-1:0]] <= x_val;
      mem_y[num_points[IDX_WIDTH-1:0]] <= y_val;
      mem_z[num_points[IDX_WIDTH-1:0]] <= acc_n;
    end
  end

  // Same-cycle read of a committing index returns the pre-write contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_x <= '0;
      rd_y <= '0;
      rd_z <= '0;
    end else begin
      rd_x <= mem_x[rd_idx];
      rd_y <= mem_y[rd_idx];
      rd_z <= mem_z[rd_idx];
    end
  end

endmodule
